// File: rtl/mips_trace_buffer_pkg.sv
// Shared types and constants for the MIPS retire-stream trace buffer.
// TRACE_TIMESTAMP_EN widens each entry with a 16-bit cycle stamp.
package mips_trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    localparam int TS_W = 16;

    // Stored entry width; the bench and the top both size entries from this.
    function automatic int entry_w(input int aw, input int iw);
`ifdef TRACE_TIMESTAMP_EN
        return aw + iw + TS_W;
`else
        return aw + iw;
`endif
    endfunction

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Retire-stream input, capture control and FWFT drain port of the trace buffer.
// TRACE_TIMESTAMP_EN adds the rd_ts signal.
interface mips_trace_buffer_if #(
    parameter int AW = 32,
    parameter int IW = 32
);
    import mips_trace_buffer_pkg::*;

    logic          trc_valid;
    logic [AW-1:0] trc_pc;
    logic [IW-1:0] trc_instr;
    logic          arm;
    logic [AW-1:0] trig_pc;
    logic          rd_ready;
    logic          rd_valid;
    logic [AW-1:0] rd_pc;
    logic [IW-1:0] rd_instr;
    logic          full;
    logic          overflow;
    state_e        state;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] rd_ts;

    modport master (
        output trc_valid, trc_pc, trc_instr, arm, trig_pc, rd_ready,
        input  rd_valid, rd_pc, rd_instr, rd_ts, full, overflow, state
    );
    modport slave (
        input  trc_valid, trc_pc, trc_instr, arm, trig_pc, rd_ready,
        output rd_valid, rd_pc, rd_instr, rd_ts, full, overflow, state
    );
`else
    modport master (
        output trc_valid, trc_pc, trc_instr, arm, trig_pc, rd_ready,
        input  rd_valid, rd_pc, rd_instr, full, overflow, state
    );
    modport slave (
        input  trc_valid, trc_pc, trc_instr, arm, trig_pc, rd_ready,
        output rd_valid, rd_pc, rd_instr, full, overflow, state
    );
`endif

endinterface

// File: rtl/mips_trace_buffer_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word reads as zero when empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mips_trace_buffer_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_P = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic             do_push, do_pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty_o = (count == '0);
    assign full_o  = (count == DEPTH_P);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = wr_ptr_q + (PW + 1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (PW + 1)'(do_pop);
    assign rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/mips_trace_buffer.sv
// Trace capture for the single-cycle MIPS retire stream: arm, trigger on a PC, buffer CAP_LEN retires.
// Define TRACE_TIMESTAMP_EN to stamp each entry with a free-running 16-bit cycle count (rd_ts).
module mips_trace_buffer
    import mips_trace_buffer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CAP_LEN = 16,
    parameter int AW      = 32,
    parameter int IW      = 32
) (
    input logic                clock,
    input logic                reset_n,
    mips_trace_buffer_if.slave bus
);
    localparam int          EW    = entry_w(AW, IW);
    localparam logic [15:0] CAP_L = 16'(CAP_LEN);

    state_e        state_q, state_d;
    logic [15:0]   cap_cnt_q, cap_cnt_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, hit;
    logic          fifo_full, fifo_empty;
    logic [EW-1:0] wdata, rdata;

    assign hit = bus.trc_valid && (bus.trc_pc == bus.trig_pc);
    assign pop = bus.rd_ready && !fifo_empty;

    // Dropping arm wins over any same-cycle trigger or push.
    always_comb begin
        state_d   = state_q;
        cap_cnt_d = cap_cnt_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.arm) begin
                    state_d   = ST_ARMED;
                    cap_cnt_d = '0;
                    ovf_d     = 1'b0;
                end
            end
            ST_ARMED: begin
                if (!bus.arm) begin
                    state_d = ST_IDLE;
                end else if (hit) begin
                    push      = 1'b1;
                    cap_cnt_d = 16'd1;
                    state_d   = (CAP_L == 16'd1) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!bus.arm) begin
                    state_d = ST_IDLE;
                end else if (bus.trc_valid) begin
                    push      = 1'b1;
                    cap_cnt_d = cap_cnt_q + 16'd1;
                    if (cap_cnt_d == CAP_L) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.arm) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Dropped entries still count toward the run length (handled above).
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cap_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_cnt_q <= cap_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clock) begin
        if (!reset_n) ts_q <= '0;
        else          ts_q <= ts_q + TS_W'(1);
    end

    assign wdata     = {ts_q, bus.trc_pc, bus.trc_instr};
    assign bus.rd_ts = rdata[AW+IW +: TS_W];
`else
    assign wdata = {bus.trc_pc, bus.trc_instr};
`endif

    mips_trace_buffer_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.rd_valid = !fifo_empty;
    assign bus.rd_pc    = rdata[IW +: AW];
    assign bus.rd_instr = rdata[IW-1:0];
    assign bus.full     = fifo_full;
    assign bus.overflow = ovf_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Scoreboard bench for mips_trace_buffer: two instances share one stimulus stream,
// A (DEPTH=4, CAP_LEN=4) for trigger/cap/disarm and B (DEPTH=4, CAP_LEN=8) for full/overflow.
module tb_mips_trace_buffer;
    import mips_trace_buffer_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    always #5 clock = ~clock;

    mips_trace_buffer_if #(.AW(32), .IW(32)) bus_a ();
    mips_trace_buffer_if #(.AW(32), .IW(32)) bus_b ();

    assign bus_b.trc_valid = bus_a.trc_valid;
    assign bus_b.trc_pc    = bus_a.trc_pc;
    assign bus_b.trc_instr = bus_a.trc_instr;
    assign bus_b.arm       = bus_a.arm;
    assign bus_b.trig_pc   = bus_a.trig_pc;
    assign bus_b.rd_ready  = bus_a.rd_ready;

    mips_trace_buffer #(.DEPTH(4), .CAP_LEN(4), .AW(32), .IW(32)) u_dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    mips_trace_buffer #(.DEPTH(4), .CAP_LEN(8), .AW(32), .IW(32)) u_dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'h1085, pc[15:0] ^ 16'h5a5a};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc);
        bus_a.trc_valid = 1'b1;
        bus_a.trc_pc    = pc;
        bus_a.trc_instr = instr_of(pc);
        step();
        bus_a.trc_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n         = 1'b0;
        bus_a.arm       = 1'b0;
        bus_a.trc_valid = 1'b0;
        bus_a.trc_pc    = '0;
        bus_a.trc_instr = '0;
        bus_a.trig_pc   = '0;
        bus_a.rd_ready  = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        bus_a.arm       = 1'b1;
        bus_a.trig_pc   = 32'h0040_0000;
        bus_a.trc_valid = 1'b1;
        bus_a.trc_pc    = 32'h0040_0000;
        bus_a.trc_instr = instr_of(32'h0040_0000);
        bus_a.rd_ready  = 1'b1;
        step();
        step();
        vectors++;
        if (bus_a.state !== ST_IDLE) begin
            errors++; $display("FAIL rst_state: got %0d expected 0", bus_a.state);
        end
        vectors++;
        if (bus_a.rd_valid !== 1'b0) begin
            errors++; $display("FAIL rst_rd_valid: got %b expected 0", bus_a.rd_valid);
        end
        vectors++;
        if (bus_a.overflow !== 1'b0) begin
            errors++; $display("FAIL rst_overflow: got %b expected 0", bus_a.overflow);
        end
        vectors++;
        if (bus_a.full !== 1'b0) begin
            errors++; $display("FAIL rst_full: got %b expected 0", bus_a.full);
        end
        vectors++;
        if (bus_a.rd_pc !== 32'h0 || bus_a.rd_instr !== 32'h0) begin
            errors++; $display("FAIL rst_rd_data: got %h/%h expected 0/0", bus_a.rd_pc, bus_a.rd_instr);
        end
        bus_a.trc_valid = 1'b0;
        bus_a.arm       = 1'b0;
        bus_a.rd_ready  = 1'b0;
        reset_n         = 1'b1;
        step();
    endtask

    task automatic test_trigger();
        apply_reset();
        bus_a.trig_pc = 32'h0040_0008;
        bus_a.arm     = 1'b1;
        step();
        vectors++;
        if (bus_a.state !== ST_ARMED) begin
            errors++; $display("FAIL trig_armed: got %0d expected 1", bus_a.state);
        end
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) exp_q.push_back(32'h0040_0000 + 32'(4 * i));
            retire(32'h0040_0000 + 32'(4 * i));
            vectors++;
            if (bus_a.rd_valid !== (i >= 2)) begin
                errors++; $display("FAIL trig_rd_valid_%0d: got %b expected %b", i, bus_a.rd_valid, (i >= 2));
            end
        end
        bus_a.rd_ready = 1'b1;
        for (int i = 0; i < 12 && bus_a.rd_valid; i++) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL trig_extra: got pc %h expected no entry", bus_a.rd_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                if (bus_a.rd_pc !== exp_pc || bus_a.rd_instr !== instr_of(exp_pc)) begin
                    errors++; $display("FAIL trig_entry: got %h/%h expected %h/%h",
                                       bus_a.rd_pc, bus_a.rd_instr, exp_pc, instr_of(exp_pc));
                end
            end
            step();
        end
        vectors++;
        if (exp_q.size() != 0 || bus_a.rd_valid !== 1'b0) begin
            errors++; $display("FAIL trig_drain: got %0d left rd_valid %b expected 0 left rd_valid 0",
                               exp_q.size(), bus_a.rd_valid);
        end
        vectors++;
        if (bus_a.state !== ST_CAPTURE) begin
            errors++; $display("FAIL trig_capture: got %0d expected 2", bus_a.state);
        end
    endtask

    task automatic test_cap_len();
        apply_reset();
        bus_a.rd_ready = 1'b1;
        bus_a.trig_pc  = 32'h0000_0100;
        bus_a.arm      = 1'b1;
        step();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_0100 + 32'(4 * i));
        for (int c = 0; c < 14; c++) begin
            bus_a.trc_valid = (c < 7);
            bus_a.trc_pc    = 32'h0000_0100 + 32'(4 * c);
            bus_a.trc_instr = instr_of(bus_a.trc_pc);
            if (bus_a.rd_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL cap_extra: got pc %h expected no entry", bus_a.rd_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (bus_a.rd_pc !== exp_pc || bus_a.rd_instr !== instr_of(exp_pc)) begin
                        errors++; $display("FAIL cap_entry: got %h/%h expected %h/%h",
                                           bus_a.rd_pc, bus_a.rd_instr, exp_pc, instr_of(exp_pc));
                    end
                end
            end
            step();
        end
        bus_a.trc_valid = 1'b0;
        vectors++;
        if (exp_q.size() != 0 || bus_a.rd_valid !== 1'b0) begin
            errors++; $display("FAIL cap_count: got %0d missing rd_valid %b expected 0 missing rd_valid 0",
                               exp_q.size(), bus_a.rd_valid);
        end
        vectors++;
        if (bus_a.state !== ST_DONE) begin
            errors++; $display("FAIL cap_done: got %0d expected 3", bus_a.state);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        bus_a.trig_pc = 32'h0000_0200;
        bus_a.arm     = 1'b1;
        step();
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) exp_q.push_back(32'h0000_0200 + 32'(4 * (i - 1)));
            retire(32'h0000_0200 + 32'(4 * (i - 1)));
            vectors++;
            if (bus_b.full !== (i >= 4)) begin
                errors++; $display("FAIL ovf_full_%0d: got %b expected %b", i, bus_b.full, (i >= 4));
            end
            vectors++;
            if (bus_b.overflow !== (i >= 5)) begin
                errors++; $display("FAIL ovf_flag_%0d: got %b expected %b", i, bus_b.overflow, (i >= 5));
            end
        end
        bus_a.rd_ready = 1'b1;
        for (int i = 0; i < 12 && bus_b.rd_valid; i++) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL ovf_extra: got pc %h expected no entry", bus_b.rd_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                if (bus_b.rd_pc !== exp_pc || bus_b.rd_instr !== instr_of(exp_pc)) begin
                    errors++; $display("FAIL ovf_entry: got %h/%h expected %h/%h",
                                       bus_b.rd_pc, bus_b.rd_instr, exp_pc, instr_of(exp_pc));
                end
            end
            step();
        end
        vectors++;
        if (exp_q.size() != 0 || bus_b.rd_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_drain: got %0d left rd_valid %b expected 0 left rd_valid 0",
                               exp_q.size(), bus_b.rd_valid);
        end
        // Two dropped retires counted, so two more end the 8-long run.
        bus_a.rd_ready = 1'b0;
        retire(32'h0000_0300);
        retire(32'h0000_0304);
        vectors++;
        if (bus_b.state !== ST_DONE || bus_b.rd_pc !== 32'h0000_0300) begin
            errors++; $display("FAIL ovf_cnt_done: got state %0d pc %h expected state 3 pc 00000300",
                               bus_b.state, bus_b.rd_pc);
        end
        vectors++;
        if (bus_b.overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got %b expected 1", bus_b.overflow);
        end
    endtask

    task automatic test_full_pop();
        apply_reset();
        bus_a.trig_pc = 32'h0000_0400;
        bus_a.arm     = 1'b1;
        step();
        for (int i = 0; i < 5; i++) exp_q.push_back(32'h0000_0400 + 32'(4 * i));
        for (int i = 0; i < 4; i++) retire(32'h0000_0400 + 32'(4 * i));
        vectors++;
        if (bus_b.full !== 1'b1) begin
            errors++; $display("FAIL fp_full_before: got %b expected 1", bus_b.full);
        end
        bus_a.rd_ready = 1'b1;
        exp_pc = exp_q.pop_front();
        vectors++;
        if (bus_b.rd_pc !== exp_pc) begin
            errors++; $display("FAIL fp_head: got %h expected %h", bus_b.rd_pc, exp_pc);
        end
        retire(32'h0000_0410);
        bus_a.rd_ready = 1'b0;
        vectors++;
        if (bus_b.full !== 1'b1 || bus_b.overflow !== 1'b0) begin
            errors++; $display("FAIL fp_after: got full %b ovf %b expected full 1 ovf 0",
                               bus_b.full, bus_b.overflow);
        end
        bus_a.rd_ready = 1'b1;
        for (int i = 0; i < 12 && bus_b.rd_valid; i++) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL fp_extra: got pc %h expected no entry", bus_b.rd_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                if (bus_b.rd_pc !== exp_pc || bus_b.rd_instr !== instr_of(exp_pc)) begin
                    errors++; $display("FAIL fp_entry: got %h/%h expected %h/%h",
                                       bus_b.rd_pc, bus_b.rd_instr, exp_pc, instr_of(exp_pc));
                end
            end
            step();
        end
        vectors++;
        if (exp_q.size() != 0 || bus_b.rd_valid !== 1'b0) begin
            errors++; $display("FAIL fp_drain: got %0d left rd_valid %b expected 0 left rd_valid 0",
                               exp_q.size(), bus_b.rd_valid);
        end
    endtask

    task automatic test_disarm();
`ifdef TRACE_TIMESTAMP_EN
        logic [15:0] prev_ts;
`endif
        apply_reset();
        bus_a.trig_pc = 32'h0000_0500;
        bus_a.arm     = 1'b1;
        step();
        exp_q.push_back(32'h0000_0500);
        exp_q.push_back(32'h0000_0504);
        retire(32'h0000_0500);
        retire(32'h0000_0504);
        bus_a.arm = 1'b0;
        retire(32'h0000_0508);
        vectors++;
        if (bus_a.state !== ST_IDLE) begin
            errors++; $display("FAIL dis_idle: got %0d expected 0", bus_a.state);
        end
        vectors++;
        if (bus_a.rd_valid !== 1'b1 || bus_a.rd_pc !== 32'h0000_0500) begin
            errors++; $display("FAIL dis_kept: got valid %b pc %h expected valid 1 pc 00000500",
                               bus_a.rd_valid, bus_a.rd_pc);
        end
`ifdef TRACE_TIMESTAMP_EN
        prev_ts = bus_a.rd_ts;
`endif
        bus_a.rd_ready = 1'b1;
        for (int i = 0; i < 12 && bus_a.rd_valid; i++) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL dis_extra: got pc %h expected no entry", bus_a.rd_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                if (bus_a.rd_pc !== exp_pc || bus_a.rd_instr !== instr_of(exp_pc)) begin
                    errors++; $display("FAIL dis_entry: got %h/%h expected %h/%h",
                                       bus_a.rd_pc, bus_a.rd_instr, exp_pc, instr_of(exp_pc));
                end
            end
`ifdef TRACE_TIMESTAMP_EN
            if (i == 1) begin
                vectors++;
                if (bus_a.rd_ts !== prev_ts + 16'd1) begin
                    errors++; $display("FAIL dis_ts: got %h expected %h", bus_a.rd_ts, prev_ts + 16'd1);
                end
            end
`endif
            step();
        end
        vectors++;
        if (exp_q.size() != 0 || bus_a.rd_valid !== 1'b0) begin
            errors++; $display("FAIL dis_drain: got %0d left rd_valid %b expected 0 left rd_valid 0",
                               exp_q.size(), bus_a.rd_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_trigger();
        test_cap_len();
        test_overflow();
        test_full_pop();
        test_disarm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
